// File: rtl/wb_burst_responder.sv
// Wishbone B4 registered-feedback RAM slave with classic, incrementing and
// wrapping burst support, plus beat/error coverage counters.
module wb_burst_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_WORDS   = 64,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [ADDR_WIDTH-1:0]   wbs_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wbs_sel_i,
  input  logic [2:0]              wbs_cti_i,
  input  logic [1:0]              wbs_bte_i,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  output logic                    wbs_ack_o,
  output logic                    wbs_err_o,
  output logic [15:0]             beat_count_o,
  output logic [7:0]              err_count_o
);

  localparam int unsigned SEL_W  = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(SEL_W);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned WCNT_W = 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, BURST} state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   acnt, acnt_n;
  logic [WCNT_W-1:0]       wcnt, wcnt_n;
  logic                    ack_n, err_n;
  logic [DATA_WIDTH-1:0]   dat_n;
  logic [ADDR_WIDTH-1:0]   start_idx;
  logic [ADDR_WIDTH-1:0]   adv_idx;
  logic [ADDR_WIDTH-1:0]   wrap_mask;
  logic [ADDR_WIDTH-1:0]   load_idx;
  logic                    present;
  logic                    wr_en;

  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
    return idx < ADDR_WIDTH'(MEM_WORDS);
  endfunction

  // Word index of the incoming address relative to the RAM base.
  assign start_idx = (wbs_adr_i - ADDR_WIDTH'(BASE_ADDR)) >> OFFS;

  // Burst address advance: linear, or wrap within an aligned N-word block.
  always_comb begin
    wrap_mask = '1;
    case (wbs_bte_i)
      2'b01:   wrap_mask = ADDR_WIDTH'(3);
      2'b10:   wrap_mask = ADDR_WIDTH'(7);
      2'b11:   wrap_mask = ADDR_WIDTH'(15);
      default: wrap_mask = '1;
    endcase
    adv_idx = (acnt & ~wrap_mask) | ((acnt + ADDR_WIDTH'(1)) & wrap_mask);
  end

  // Next-state, address counter and next registered response.
  always_comb begin
    state_n  = state;
    acnt_n   = acnt;
    wcnt_n   = wcnt;
    ack_n    = 1'b0;
    err_n    = 1'b0;
    dat_n    = '0;
    load_idx = acnt;
    present  = 1'b0;
    wr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i && !wbs_ack_o && !wbs_err_o) begin
          acnt_n   = start_idx;
          load_idx = start_idx;
          if (WAIT_STATES == 0) begin
            present = 1'b1;
            state_n = RESP;
          end else begin
            wcnt_n  = WCNT_W'(WAIT_STATES);
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          state_n = IDLE;
        end else begin
          wcnt_n = wcnt - WCNT_W'(1);
          if (wcnt_n == '0) begin
            present = 1'b1;
            state_n = RESP;
          end
        end
      end
      RESP: begin
        if (!wbs_cyc_i || wbs_err_o) begin
          state_n = IDLE;
        end else if (wbs_stb_i) begin
          wr_en  = wbs_we_i;
          acnt_n = adv_idx;
          if (wbs_cti_i == 3'b010) begin
            load_idx = adv_idx;
            present  = 1'b1;
            state_n  = BURST;
          end else begin
            state_n = IDLE;
          end
        end else begin
          // Strobe withdrawn before completing: keep presenting the beat.
          present = 1'b1;
        end
      end
      BURST: begin
        if (!wbs_cyc_i) begin
          state_n = IDLE;
        end else if (wbs_ack_o) begin
          if (wbs_stb_i) begin
            wr_en  = wbs_we_i;
            acnt_n = adv_idx;
            if (wbs_cti_i == 3'b111) begin
              state_n = IDLE;
            end else begin
              load_idx = adv_idx;
              present  = 1'b1;
            end
          end
        end else if (wbs_stb_i) begin
          present = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (present) begin
      if (in_range(load_idx)) begin
        ack_n = 1'b1;
        dat_n = mem[load_idx[IDX_W-1:0]];
      end else begin
        // Error beat is terminal: RESP drops back to IDLE after it.
        err_n   = 1'b1;
        state_n = RESP;
      end
    end
  end

  // State, address counter, registered bus outputs and coverage counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acnt         <= '0;
      wcnt         <= '0;
      wbs_ack_o    <= 1'b0;
      wbs_err_o    <= 1'b0;
      wbs_dat_o    <= '0;
      beat_count_o <= '0;
      err_count_o  <= '0;
    end else begin
      state        <= state_n;
      acnt         <= acnt_n;
      wcnt         <= wcnt_n;
      wbs_ack_o    <= ack_n;
      wbs_err_o    <= err_n;
      wbs_dat_o    <= dat_n;
      beat_count_o <= beat_count_o + 16'(ack_n);
      if (err_n && (err_count_o != 8'hFF)) begin
        err_count_o <= err_count_o + 8'd1;
      end
    end
  end

  // RAM write with byte-lane enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < SEL_W; k++) begin
        if (wbs_sel_i[k]) begin
          mem[acnt[IDX_W-1:0]][k*8 +: 8] <= wbs_dat_i[k*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_responder.sv
// Self-checking bench for wb_burst_responder: directed scenarios plus a
// randomized burst mix checked against a word-array reference model.
module tb_wb_burst_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat_i = '0;
  logic [3:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  int          dsel = 0;

  logic [31:0] dat0, dat2;
  logic        ack0, err0, ack2, err2;
  logic [15:0] bc0, bc2;
  logic [7:0]  ec0, ec2;
  logic        cyc0, cyc2, ack_m, err_m;
  logic [31:0] dat_m;

  assign cyc0  = cyc && (dsel == 0);
  assign cyc2  = cyc && (dsel == 1);
  assign ack_m = (dsel == 1) ? ack2 : ack0;
  assign err_m = (dsel == 1) ? err2 : err0;
  assign dat_m = (dsel == 1) ? dat2 : dat0;

  always #5 clk = ~clk;

  wb_burst_responder #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wbs_cyc_i(cyc0), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_sel_i(sel), .wbs_cti_i(cti),
    .wbs_bte_i(bte), .wbs_dat_o(dat0), .wbs_ack_o(ack0), .wbs_err_o(err0),
    .beat_count_o(bc0), .err_count_o(ec0));

  wb_burst_responder #(.WAIT_STATES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wbs_cyc_i(cyc2), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_sel_i(sel), .wbs_cti_i(cti),
    .wbs_bte_i(bte), .wbs_dat_o(dat2), .wbs_ack_o(ack2), .wbs_err_o(err2),
    .beat_count_o(bc2), .err_count_o(ec2));

  int total = 0;
  int bad = 0;

  // Master-side transfer record.
  logic [31:0] wdata [16];
  logic [3:0]  wsel  [16];
  logic [31:0] rdata [16];
  int          ack_cyc [16];
  int          nacks, err_cyc;
  bit          got_err;
  logic        ack_after;

  // Reference model: one word array per DUT plus expected results.
  logic [31:0] mm [2][64];
  logic [31:0] exp_rd [16];
  int          exp_nack;
  bit          exp_err;
  int          mbeats [2];
  int          merrs [2];

  function automatic logic [2:0] cti_of(input int k, input int n);
    if (n == 1) return 3'b000;
    if (k == n - 1) return 3'b111;
    return 3'b010;
  endfunction

  function automatic int unsigned seq_idx(input int unsigned w0, input int i, input logic [1:0] b);
    int unsigned nw;
    if (b == 2'b00) return w0 + i;
    nw = 1 << (int'(b) + 1);
    return (w0 / nw) * nw + (w0 + i) % nw;
  endfunction

  // Predict acked beats, error, read data; apply writes to the model.
  task automatic model_apply(input bit w, input logic [31:0] a, input int n, input logic [1:0] b);
    int unsigned idx;
    exp_nack = 0;
    exp_err  = 0;
    for (int i = 0; i < n; i++) begin
      idx = seq_idx(a >> 2, i, b);
      if (idx >= 64) begin
        exp_err = 1;
        break;
      end
      if (w) begin
        for (int l = 0; l < 4; l++)
          if (wsel[i][l]) mm[dsel][idx][8*l +: 8] = wdata[i][8*l +: 8];
      end else begin
        exp_rd[i] = mm[dsel][idx];
      end
      exp_nack++;
    end
    mbeats[dsel] += exp_nack;
    if (exp_err && merrs[dsel] < 255) merrs[dsel]++;
  endtask

  // Registered-feedback master: a beat completes on the edge ending an ack cycle.
  task automatic run_burst(input bit w, input logic [31:0] a, input int n,
                           input logic [1:0] b, input int abort_at);
    int   k, cn;
    logic prev_ack;
    nacks = 0; got_err = 0; err_cyc = -1; ack_after = 1'b0;
    k = 0; cn = 0; prev_ack = 1'b0;
    cyc = 1; stb = 1; we = w; adr = a; bte = b;
    dat_i = wdata[0]; sel = wsel[0]; cti = cti_of(0, n);
    while (1) begin
      @(posedge clk); #1; cn++;
      if (got_err) begin
        cyc = 0; stb = 0; cti = 3'b000;
        ack_after = ack_m | err_m;
        break;
      end
      if (prev_ack) begin
        k++;
        if (k == n) begin
          cyc = 0; stb = 0; cti = 3'b000;
          ack_after = ack_m | err_m;
          break;
        end
        if (k == abort_at) begin
          cyc = 0; stb = 0;
          @(posedge clk); #1;
          ack_after = ack_m | err_m;
          break;
        end
        adr = $urandom;
        dat_i = wdata[k]; sel = wsel[k]; cti = cti_of(k, n);
      end
      if (ack_m) begin
        rdata[k] = dat_m; ack_cyc[k] = cn; nacks++;
      end
      if (err_m) begin
        got_err = 1; err_cyc = cn;
      end
      prev_ack = ack_m;
      if (cn > 80) begin
        total++; bad++;
        $display("FAIL burst_timeout: cycles=%0d beats=%0d required=%0d", cn, k, n);
        cyc = 0; stb = 0;
        break;
      end
    end
  endtask

  task automatic xfer(input bit w, input logic [31:0] a, input int n, input logic [1:0] b);
    model_apply(w, a, n, b);
    run_burst(w, a, n, b, -1);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ack0 !== 1'b0 || err0 !== 1'b0) begin bad++; $display("FAIL reset_ack_err: ack=%b err=%b required 0 0", ack0, err0); end
    total++; if (dat0 !== 32'h0) begin bad++; $display("FAIL reset_dat: got=%h required=0", dat0); end
    total++; if (bc0 !== 16'h0 || ec0 !== 8'h0) begin bad++; $display("FAIL reset_counts: beats=%0d errs=%0d required 0 0", bc0, ec0); end
    total++; if (ack2 !== 1'b0 || bc2 !== 16'h0) begin bad++; $display("FAIL reset_dut2: ack=%b beats=%0d required 0 0", ack2, bc2); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_classic();
    dsel = 0;
    wdata[0] = 32'hDEADBEEF; wsel[0] = 4'hF;
    xfer(1, 32'h10, 1, 2'b00);
    total++; if (nacks != 1 || ack_cyc[0] != 1) begin bad++; $display("FAIL classic_wr_ack: acks=%0d cycle=%0d required 1 1", nacks, ack_cyc[0]); end
    total++; if (ack_after !== 1'b0) begin bad++; $display("FAIL classic_wr_pulse: ack_after=%b required 0", ack_after); end
    xfer(0, 32'h10, 1, 2'b00);
    total++; if (rdata[0] !== 32'hDEADBEEF || ack_cyc[0] != 1) begin bad++; $display("FAIL classic_rd: got=%h cycle=%0d required deadbeef 1", rdata[0], ack_cyc[0]); end
    total++; if (ack_after !== 1'b0) begin bad++; $display("FAIL classic_rd_pulse: ack_after=%b required 0", ack_after); end
    total++; if (bc0 !== 16'd2) begin bad++; $display("FAIL classic_beats: got=%0d required=2", bc0); end
  endtask

  task automatic test_incr_burst();
    dsel = 0;
    for (int i = 0; i < 8; i++) begin wdata[i] = i; wsel[i] = 4'hF; end
    xfer(1, 32'h0, 8, 2'b00);
    total++; if (nacks != 8 || ack_cyc[7] != 8 || ack_after !== 1'b0) begin bad++; $display("FAIL incr_wr: acks=%0d last=%0d after=%b required 8 8 0", nacks, ack_cyc[7], ack_after); end
    xfer(0, 32'h0, 8, 2'b00);
    for (int i = 0; i < 8; i++) begin
      total++; if (rdata[i] !== 32'(i) || ack_cyc[i] != i + 1) begin bad++; $display("FAIL incr_rd[%0d]: got=%h cycle=%0d required %h %0d", i, rdata[i], ack_cyc[i], i, i + 1); end
    end
    total++; if (ack_after !== 1'b0) begin bad++; $display("FAIL incr_rd_end: ack_after=%b required 0", ack_after); end
  endtask

  task automatic test_wait_states();
    dsel = 1;
    for (int i = 0; i < 4; i++) begin wdata[i] = $urandom; wsel[i] = 4'hF; end
    xfer(1, 32'h20, 4, 2'b00);
    xfer(0, 32'h20, 4, 2'b00);
    total++; if (nacks != 4 || ack_cyc[0] != 3) begin bad++; $display("FAIL ws_first: acks=%0d first=%0d required 4 3", nacks, ack_cyc[0]); end
    for (int i = 1; i < 4; i++) begin
      total++; if (ack_cyc[i] != 3 + i) begin bad++; $display("FAIL ws_b2b[%0d]: cycle=%0d required=%0d", i, ack_cyc[i], 3 + i); end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (rdata[i] !== exp_rd[i]) begin bad++; $display("FAIL ws_data[%0d]: got=%h required=%h", i, rdata[i], exp_rd[i]); end
    end
    dsel = 0;
  endtask

  task automatic test_wrap4();
    logic [31:0] want [4];
    dsel = 0;
    for (int i = 0; i < 4; i++) begin wdata[i] = 32'hA0 + i; wsel[i] = 4'hF; end
    xfer(1, 32'h0, 4, 2'b00);
    want[0] = 32'hA2; want[1] = 32'hA3; want[2] = 32'hA0; want[3] = 32'hA1;
    xfer(0, 32'h08, 4, 2'b01);
    for (int i = 0; i < 4; i++) begin
      total++; if (rdata[i] !== want[i]) begin bad++; $display("FAIL wrap4[%0d]: got=%h required=%h", i, rdata[i], want[i]); end
    end
  endtask

  task automatic test_byte_lanes();
    dsel = 0;
    wdata[0] = 32'hFFFFFFFF; wsel[0] = 4'hF;
    xfer(1, 32'h40, 1, 2'b00);
    wdata[0] = 32'h12345678; wsel[0] = 4'b0101;
    xfer(1, 32'h40, 1, 2'b00);
    xfer(0, 32'h40, 1, 2'b00);
    total++; if (rdata[0] !== 32'hFF34FF78) begin bad++; $display("FAIL byte_lanes: got=%h required=ff34ff78", rdata[0]); end
  endtask

  task automatic test_errors();
    dsel = 0;
    xfer(0, 32'h100, 1, 2'b00);
    total++; if (!got_err || nacks != 0) begin bad++; $display("FAIL oor_err: err=%0d acks=%0d required 1 0", got_err, nacks); end
    total++; if (ec0 !== 8'd1) begin bad++; $display("FAIL oor_count: got=%0d required=1", ec0); end
    xfer(0, 32'(62 * 4), 4, 2'b00);
    total++; if (nacks != 2 || !got_err || err_cyc != 3) begin bad++; $display("FAIL edge_burst: acks=%0d err=%0d errcyc=%0d required 2 1 3", nacks, got_err, err_cyc); end
    total++; if (ack_after !== 1'b0) begin bad++; $display("FAIL edge_idle: ack_or_err_after=%b required 0", ack_after); end
    xfer(0, 32'(62 * 4), 1, 2'b00);
    total++; if (nacks != 1 || got_err || rdata[0] !== exp_rd[0]) begin bad++; $display("FAIL after_err_rd: acks=%0d err=%0d got=%h required 1 0 %h", nacks, got_err, rdata[0], exp_rd[0]); end
    total++; if (ec0 !== 8'd2) begin bad++; $display("FAIL err_count: got=%0d required=2", ec0); end
  endtask

  task automatic test_random();
    bit          w;
    int          n;
    logic [1:0]  b;
    int unsigned w0;
    dsel = 0;
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 16; i++) begin wdata[i] = $urandom; wsel[i] = 4'hF; end
      xfer(1, 32'(blk * 64), 16, 2'b00);
    end
    for (int it = 0; it < 40; it++) begin
      w  = 1'($urandom_range(1));
      n  = $urandom_range(1, 8);
      b  = 2'($urandom_range(3));
      w0 = $urandom_range(0, 67);
      for (int i = 0; i < 16; i++) begin wdata[i] = $urandom; wsel[i] = 4'($urandom); end
      xfer(w, 32'(w0 * 4), n, b);
      total++; if (nacks != exp_nack || got_err != exp_err) begin bad++; $display("FAIL rnd%0d_beats: acks=%0d err=%0d required %0d %0d", it, nacks, got_err, exp_nack, exp_err); end
      if (!w) begin
        for (int i = 0; i < exp_nack; i++) begin
          total++; if (rdata[i] !== exp_rd[i]) begin bad++; $display("FAIL rnd%0d_rd[%0d]: got=%h required=%h", it, i, rdata[i], exp_rd[i]); end
        end
      end
    end
    total++; if (bc0 !== 16'(mbeats[0])) begin bad++; $display("FAIL beat_count: got=%0d required=%0d", bc0, mbeats[0]); end
    total++; if (ec0 !== 8'(merrs[0])) begin bad++; $display("FAIL err_count_total: got=%0d required=%0d", ec0, merrs[0]); end
  endtask

  task automatic test_abort();
    dsel = 0;
    for (int i = 0; i < 4; i++) begin wdata[i] = 32'h5500 + i; wsel[i] = 4'hF; end
    xfer(1, 32'(20 * 4), 4, 2'b00);
    for (int i = 0; i < 4; i++) begin wdata[i] = 32'hC0DE0000 + i; wsel[i] = 4'hF; end
    run_burst(1, 32'(20 * 4), 4, 2'b00, 1);
    mm[0][20] = 32'hC0DE0000;
    total++; if (ack_after !== 1'b0 || nacks != 1) begin bad++; $display("FAIL abort_ack: after=%b acks=%0d required 0 1", ack_after, nacks); end
    xfer(0, 32'(20 * 4), 4, 2'b00);
    for (int i = 0; i < 4; i++) begin
      total++; if (rdata[i] !== exp_rd[i]) begin bad++; $display("FAIL abort_mem[%0d]: got=%h required=%h", i, rdata[i], exp_rd[i]); end
    end
  endtask

  task automatic test_reset_midburst();
    dsel = 0;
    cyc = 1; stb = 1; we = 0; adr = 32'(20 * 4); cti = 3'b010; bte = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    total++; if (ack0 !== 1'b0 || dat0 !== 32'h0 || bc0 !== 16'h0 || ec0 !== 8'h0) begin bad++; $display("FAIL midburst_reset: ack=%b dat=%h beats=%0d errs=%0d required 0 0 0 0", ack0, dat0, bc0, ec0); end
    cyc = 0; stb = 0; cti = 3'b000;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    xfer(0, 32'(20 * 4), 1, 2'b00);
    total++; if (rdata[0] !== 32'hC0DE0000) begin bad++; $display("FAIL retained: got=%h required=c0de0000", rdata[0]); end
  endtask

  initial begin
    mbeats[0] = 0; mbeats[1] = 0; merrs[0] = 0; merrs[1] = 0;
    test_reset();
    test_classic();
    test_incr_burst();
    test_wait_states();
    test_wrap4();
    test_byte_lanes();
    test_errors();
    test_random();
    test_abort();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_burst_responder.md
# wb_burst_responder

Wishbone B4 registered-feedback slave that answers the burst cycles issued by the fuzzer bridge's master port. It backs a word-organised RAM and supports classic cycles, incrementing bursts and wrapping bursts. It sits on the bridge's master bus as the fuzz-target memory and counts completed beats and errors for coverage. The block has one clock and an asynchronous, active-low reset.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; word size = DATA_WIDTH/8 bytes
- MEM_WORDS, 64, RAM depth in words; power of two
- BASE_ADDR, 0, byte address of word 0; aligned to MEM_WORDS*DATA_WIDTH/8
- WAIT_STATES, 0, extra cycles before the first ack of each cycle/burst (0..3)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone cycle/strobe/write-enable
- wbs_adr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- wbs_dat_i  in  DATA_WIDTH  write data
- wbs_sel_i  in  DATA_WIDTH/8  byte lane enables (writes only)
- wbs_cti_i  in  3  000 classic, 010 incrementing, 111 end-of-burst
- wbs_bte_i  in  2  00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16
- wbs_dat_o  out  DATA_WIDTH  read data, valid while wbs_ack_o=1
- wbs_ack_o  out  1  beat acknowledge
- wbs_err_o  out  1  error termination (out-of-range address)
- beat_count_o  out  16  total acked beats, wraps modulo 2^16
- err_count_o  out  8  err responses, saturates at 255

## Operation
- Word index = (address − BASE_ADDR) >> log2(DATA_WIDTH/8). An address is in range when 0 ≤ index < MEM_WORDS. An out-of-range address gets err instead of ack, and no write occurs.
- States:
  - IDLE -> WAIT: on cyc&stb with ack=err=0. The start address is latched into the internal address counter acnt, and the wait counter is loaded with WAIT_STATES.
  - WAIT -> RESP: when the wait counter reaches 0. With WAIT_STATES=0, WAIT lasts zero cycles.
  - RESP: ack (or err) is high for exactly one beat. Then:
    - BURST, if cti sampled during the ack beat is 010 and the access was in range;
    - IDLE, otherwise. This covers 000, 111 and any other cti value, and err.
  - BURST: ack stays high every cycle that cyc&stb=1. acnt advances once per acked beat. After the beat on which cti=111 is sampled, go to IDLE.
- acnt update per bte:
  - linear: +1 word;
  - wrap-N: low log2(N) bits increment modulo N, upper bits held.
- Address source:
  - The first beat uses latched wbs_adr_i.
  - Later beats use acnt only; wbs_adr_i is ignored after the first beat.
- Writes: each acked beat writes wbs_dat_i into mem[acnt], byte lane k only when wbs_sel_i[k]=1.
- Reads: wbs_dat_o = mem[acnt] registered, presented in the same cycle as ack. An out-of-range read drives 0.
- RAM contents are not reset.

## Timing
- Reset: wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, beat_count_o=0, err_count_o=0, state IDLE, acnt=0.
- First-beat latency: ack rises 1+WAIT_STATES cycles after the edge where cyc&stb is first sampled high.
- Classic cycle: ack is a one-cycle pulse. The slave then spends at least one cycle in IDLE, so it never re-acks a strobe the master has not yet dropped.
- Burst of L beats: ack is high for L consecutive cycles after the first ack, provided stb stays high. Total = 1+WAIT_STATES+L cycles.
- stb low with cyc high in BURST: ack=0 that cycle, acnt held, no write. Resume acking on the next cycle stb=1.
- cyc low in any state: abort to IDLE next edge; ack=err=0; no write on the abort cycle.
- Out-of-range beat mid-burst (acnt crosses MEM_WORDS on a linear burst): err on that beat, no write, state returns to IDLE.
- Counters:
  - beat_count_o increments on every ack cycle.
  - err_count_o increments on every err cycle.
- ack and err are never high together.
- Reset asserted mid-burst: outputs are forced to reset values immediately (asynchronous); previously written words are retained.

## Test plan
- Classic write 0xDEADBEEF to 0x10 with sel=1111, then classic read of 0x10. Required: each ack is a 1-cycle pulse 1 cycle after stb (WAIT_STATES=0); read returns 0xDEADBEEF; beat_count_o=2.
- 8-beat incrementing write from 0x00, data 0..7 (cti 010 ×7, then 111), followed by the matching burst read. Required: 8 consecutive ack cycles each way; reads return 0..7; ack drops after the 111 beat.
- WAIT_STATES=2, 4-beat burst read. Required: first ack 3 cycles after stb, then 3 back-to-back acks; total 7 cycles.
- Wrap-4 read starting at 0x08 over words preloaded 0xA0..0xA3. Required: data order 0xA2, 0xA3, 0xA0, 0xA1.
- Byte lanes: write 0xFFFFFFFF, then write 0x12345678 with sel=0101, then read. Required: read returns 0xFF34FF78.
- Read at BASE_ADDR+MEM_WORDS*4 gets err (not ack) and err_count_o=1. A linear burst from word 62 gives ack, ack, then err, and the block returns to IDLE. Dropping cyc on beat 2 of a burst gives ack=0 next cycle and no further writes.
